mdp_result_reader: RTL and testbench
====================================

# mdp_result_reader

Host-side consumer for the MDP solver's completion handshake. When the solver raises `MDP_done`, this block captures the flat utility and policy buses in one cycle. It then streams them out one grid cell per valid/ready transfer, tagged with row/column, and completes the four-phase handshake by driving `ack` until `MDP_done` falls. It sits between `MD_state_machine` and any display/UART/logging sink.

## Interface
- `MAX_CELLS`, 32, capacity of the flat grid buses
- `UTIL_W`, 16, utility width (IEEE fp16)
- `POL_W`, 2, policy code width
- `clk`  in  1  system clock; everything on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `MDP_done`  in  1  solver result valid (held until `ack` seen)
- `ack`  out  1  result consumed; held high until `MDP_done` low
- `cur_util`  in  MAX_CELLS*UTIL_W  cell i at bits [i*16 +: 16]
- `policy`  in  MAX_CELLS*POL_W  cell i at bits [i*2 +: 2]
- `in_width`, `in_depth`  in  8 each  grid dimensions
- `out_valid`  out  1  stream beat valid
- `out_ready`  in  1  sink accepts beat
- `out_index`  out  5  flat cell index
- `out_row`, `out_col`  out  8 each  cell coordinates (row = index / width)
- `out_util`  out  16  captured utility
- `out_policy`  out  2  captured policy (00 Up, 01 Down, 10 Left, 11 Right)
- `out_last`  out  1  final beat of the grid
- `busy`  out  1  not in IDLE
- `err`  out  1  sticky: last grid had illegal cell count
- `max_util`, `max_index`  out  16, 5  only with `MDP_READER_MAXUTIL_EN`

## Operation
- States: IDLE, STREAM, ACK.
- IDLE: when `MDP_done`=1, register the snapshot (`cur_util`, `policy`, n = `in_width`*`in_depth`, width), clear index/row/col and `err`.
  - If n==0 or n>MAX_CELLS, set `err` and go to ACK.
  - Otherwise go to STREAM.
- STREAM: `out_valid`=1 and outputs reflect the snapshot at the current index.
  - On `out_valid & out_ready`: index++, col++; when col==width-1, col←0 and row++.
  - `out_last` = (index==n-1). A transfer with `out_last` goes to ACK.
  - `out_valid` never drops without a transfer; outputs are stable while stalled.
- ACK: `ack`=1. When `MDP_done` is sampled 0, go to IDLE (`ack` deasserts that edge).
- Row/col come from counters; no divider.
- Input changes after capture are ignored until the next IDLE capture.
- If `MDP_done` is still high on return to IDLE, that is impossible by construction: IDLE is entered only after it is low.

## Timing
- Reset values: state IDLE; `ack`, `out_valid`, `out_last`, `busy`, `err` = 0; data outputs 0; `max_util` = 0xFC00 (−inf); `max_index` = 0.
- `MDP_done` sampled high at edge k: `out_valid`=1 from cycle k+1.
- With `out_ready` tied 1: n beats on cycles k+1..k+n, `ack`=1 from k+n+1.
- Error path: `ack`=1 from k+1.
- `ack` falls one cycle after `MDP_done` is sampled low.
- Reset mid-stream aborts immediately: no `ack`, no further beats. If `MDP_done` is still high after reset, a fresh capture starts on the first cycle out of reset.

## Configuration
- `MDP_READER_MAXUTIL_EN` defined:
  - During STREAM, each accepted beat is compared with the running maximum, using fp16 ordering key = sign ? ~x : x^16'h8000, unsigned compare.
  - Ties keep the lower index.
  - `max_util`/`max_index` update with each accepted beat, reset to 0xFC00/0 on capture, and hold through ACK.
- Undefined: the comparator, `max_util`, and `max_index` are absent from the design.

## Structure
- Shared package `mdp_pkg`:
  - `MAX_CELLS`, `UTIL_W`, `POL_W`
  - policy codes `POL_UP`/`POL_DOWN`/`POL_LEFT`/`POL_RIGHT`
  - cell-type codes (00 empty, 01 positive, 10 negative, 11 wall)
  - reader state enum
  - `FP16_NEG_INF`
- Sub-module `mdp_fp16_max`: combinational key compare, instantiated only under the macro.

## Test plan
- 4×3 grid, util[3]=0x3C00, util[7]=0xBC00, others 0, `out_ready`=1, `MDP_done` at edge k:
  - 12 beats k+1..k+12
  - beat 3 = row0/col3/0x3C00; beat 7 = row1/col3/0xBC00
  - `out_last` only on index 11; `ack` at k+13
- Same grid, `out_ready` toggling 1,0,0,1…: every beat delivered once, held stable while stalled, order 0..11.
- `in_width`=0, or 8×5=40: `err`=1, zero beats, `ack` at k+1.
- Hold `MDP_done` high 5 cycles in ACK, then drop: `ack` stays high; falls the cycle after `MDP_done` sampled low; `busy`=0.
- `Reset` at beat 5 of 12 with `MDP_done` still high: outputs at reset values, then a fresh stream starts at index 0.
- `MDP_READER_MAXUTIL_EN`, utils {0xBC00, 0x3800, 0x3C00, 0x3C00}: `max_util`=0x3C00, `max_index`=2.

Source files
------------

// File: rtl/mdp_pkg.sv
// -----------------------------------------------------------------------------
// mdp_pkg
// Shared definitions for the MDP solver result path.
//   - Grid bus geometry: MAX_CELLS, UTIL_W, POL_W, IDX_W
//   - Policy codes (Up/Down/Left/Right) and cell-type codes
//   - Result reader state enum
//   - fp16 constants and the fp16 ordering-key helper
// -----------------------------------------------------------------------------
package mdp_pkg;

    localparam int MAX_CELLS = 32;
    localparam int UTIL_W    = 16;
    localparam int POL_W     = 2;
    localparam int IDX_W     = $clog2(MAX_CELLS);

    // Policy codes carried on the policy bus
    localparam logic [POL_W-1:0] POL_UP    = 2'b00;
    localparam logic [POL_W-1:0] POL_DOWN  = 2'b01;
    localparam logic [POL_W-1:0] POL_LEFT  = 2'b10;
    localparam logic [POL_W-1:0] POL_RIGHT = 2'b11;

    // Grid cell-type codes
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_POS   = 2'b01;
    localparam logic [1:0] CELL_NEG   = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    // fp16 negative infinity: the identity for a running maximum
    localparam logic [UTIL_W-1:0] FP16_NEG_INF = 16'hFC00;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'b00,
        RD_STREAM = 2'b01,
        RD_ACK    = 2'b10
    } rd_state_t;

    // Maps an fp16 value onto an unsigned key whose integer order matches the
    // floating-point order: negatives are bit-inverted, positives get the sign
    // bit set so they sort above every negative.
    function automatic logic [UTIL_W-1:0] fp16_key(input logic [UTIL_W-1:0] x);
        fp16_key = x[UTIL_W-1] ? ~x : (x ^ 16'h8000);
    endfunction

endpackage

// File: rtl/mdp_fp16_max.sv
// -----------------------------------------------------------------------------
// mdp_fp16_max
// Combinational fp16 "strictly greater than" compare using the ordering key.
// A tie reports not-greater, so a running maximum keeps its earlier entry.
// Ports:
//   i_cand    - candidate fp16 value
//   i_cur     - current maximum fp16 value
//   o_greater - 1 when i_cand orders strictly above i_cur
// -----------------------------------------------------------------------------
module mdp_fp16_max
    import mdp_pkg::*;
(
    input  logic [UTIL_W-1:0] i_cand,
    input  logic [UTIL_W-1:0] i_cur,
    output logic              o_greater
);

    assign o_greater = (fp16_key(i_cand) > fp16_key(i_cur));

endmodule

// File: rtl/mdp_result_reader.sv
// -----------------------------------------------------------------------------
// mdp_result_reader
// Host-side consumer of the MDP solver completion handshake. On MDP_done it
// snapshots the flat utility/policy buses and the grid size, streams one cell
// per valid/ready transfer tagged with index/row/column, then holds ack until
// MDP_done falls (four-phase handshake).
//
// Optional feature (macro MDP_READER_MAXUTIL_EN): tracks the maximum utility
// seen over the accepted beats and its index on max_util / max_index.
//
// Ports:
//   clk, Reset              - clock, synchronous active-high reset
//   MDP_done / ack          - solver handshake (ack held until MDP_done low)
//   cur_util, policy        - flat grid buses, cell i at [i*W +: W]
//   in_width, in_depth      - grid dimensions (cells = width*depth)
//   out_valid/out_ready     - per-cell stream handshake
//   out_index/row/col       - flat index and coordinates of the current beat
//   out_util/out_policy     - captured cell contents
//   out_last                - final beat of the grid
//   busy                    - not idle
//   err                     - sticky: last grid had an illegal cell count
//   max_util/max_index      - running maximum (macro builds only)
// -----------------------------------------------------------------------------
module mdp_result_reader
    import mdp_pkg::*;
(
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        MDP_done,
    output logic                        ack,
    input  logic [MAX_CELLS*UTIL_W-1:0] cur_util,
    input  logic [MAX_CELLS*POL_W-1:0]  policy,
    input  logic [7:0]                  in_width,
    input  logic [7:0]                  in_depth,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_index,
    output logic [7:0]                  out_row,
    output logic [7:0]                  out_col,
    output logic [UTIL_W-1:0]           out_util,
    output logic [POL_W-1:0]            out_policy,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err
`ifdef MDP_READER_MAXUTIL_EN
    ,
    output logic [UTIL_W-1:0]           max_util,
    output logic [IDX_W-1:0]            max_index
`endif
);

    rd_state_t                   r_state;
    logic                        r_ack;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic                        r_busy;
    logic                        r_err;
    logic [IDX_W-1:0]            r_index;
    logic [IDX_W-1:0]            r_last_index;
    logic [7:0]                  r_row;
    logic [7:0]                  r_col;
    logic [7:0]                  r_width;
    logic [UTIL_W-1:0]           r_out_util;
    logic [POL_W-1:0]            r_out_policy;
    logic [MAX_CELLS*UTIL_W-1:0] r_util_snap;
    logic [MAX_CELLS*POL_W-1:0]  r_pol_snap;

    logic [15:0]                 w_cell_count;
    logic                        w_count_bad;
    logic                        w_capture;
    logic                        w_fire;
    logic [IDX_W-1:0]            w_next_index;
    logic [IDX_W+4:0]            w_util_off;
    logic [IDX_W:0]              w_pol_off;

    // Full 16-bit product so oversized grids (up to 255*255) are caught.
    assign w_cell_count = {8'd0, in_width} * {8'd0, in_depth};
    assign w_count_bad  = (w_cell_count == 16'd0) || (w_cell_count > 16'(MAX_CELLS));
    assign w_capture    = (r_state == RD_IDLE) && MDP_done;
    assign w_fire       = r_out_valid && out_ready;
    assign w_next_index = r_index + IDX_W'(1);
    // Bit offsets of the next cell: index*16 for utility, index*2 for policy.
    assign w_util_off   = {w_next_index, 4'b0000};
    assign w_pol_off    = {w_next_index, 1'b0};

    // Reader FSM: capture, stream one cell per transfer, four-phase ack.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= RD_IDLE;
            r_ack        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_index      <= '0;
            r_last_index <= '0;
            r_row        <= 8'd0;
            r_col        <= 8'd0;
            r_width      <= 8'd0;
            r_out_util   <= '0;
            r_out_policy <= '0;
            r_util_snap  <= '0;
            r_pol_snap   <= '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_capture) begin
                        r_util_snap  <= cur_util;
                        r_pol_snap   <= policy;
                        r_width      <= in_width;
                        // A count of MAX_CELLS truncates to 0 and wraps to MAX_CELLS-1.
                        r_last_index <= w_cell_count[IDX_W-1:0] - IDX_W'(1);
                        r_index      <= '0;
                        r_row        <= 8'd0;
                        r_col        <= 8'd0;
                        r_out_util   <= cur_util[UTIL_W-1:0];
                        r_out_policy <= policy[POL_W-1:0];
                        r_busy       <= 1'b1;
                        if (w_count_bad) begin
                            r_err       <= 1'b1;
                            r_ack       <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= RD_ACK;
                        end else begin
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (w_cell_count == 16'd1);
                            r_state     <= RD_STREAM;
                        end
                    end
                end
                RD_STREAM: begin
                    if (w_fire) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_ack       <= 1'b1;
                            r_state     <= RD_ACK;
                        end else begin
                            r_index      <= w_next_index;
                            if (r_col == (r_width - 8'd1)) begin
                                r_col <= 8'd0;
                                r_row <= r_row + 8'd1;
                            end else begin
                                r_col <= r_col + 8'd1;
                            end
                            r_out_util   <= r_util_snap[w_util_off +: UTIL_W];
                            r_out_policy <= r_pol_snap[w_pol_off +: POL_W];
                            r_out_last   <= (w_next_index == r_last_index);
                        end
                    end
                end
                RD_ACK: begin
                    if (!MDP_done) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= RD_IDLE;
                    end
                end
                default: begin
                    r_state     <= RD_IDLE;
                    r_ack       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign err        = r_err;
    assign out_index  = r_index;
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_util   = r_out_util;
    assign out_policy = r_out_policy;

`ifdef MDP_READER_MAXUTIL_EN
    logic              w_greater;
    logic [UTIL_W-1:0] r_max_util;
    logic [IDX_W-1:0]  r_max_index;

    mdp_fp16_max u_fp16_max (
        .i_cand    (r_out_util),
        .i_cur     (r_max_util),
        .o_greater (w_greater)
    );

    // Running maximum over accepted beats; a tie keeps the earlier (lower) index.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_max_util  <= FP16_NEG_INF;
            r_max_index <= '0;
        end else if (w_capture) begin
            r_max_util  <= FP16_NEG_INF;
            r_max_index <= '0;
        end else if (w_fire && w_greater) begin
            r_max_util  <= r_out_util;
            r_max_index <= r_index;
        end
    end

    assign max_util  = r_max_util;
    assign max_index = r_max_index;
`endif

endmodule

// File: tb/tb_mdp_result_reader.sv
// -----------------------------------------------------------------------------
// tb_mdp_result_reader
// Self-checking bench for mdp_result_reader. A table of grid shapes with their
// expected error flag and beat count drives a common stream checker; each
// beat is compared with a reference built from plain arithmetic (row = i/w,
// col = i%w). Hand-written sequences cover the fixed 4x3 grid, stalls, a long
// ack hold, a mid-stream reset and (macro builds) the running maximum.
// -----------------------------------------------------------------------------
module tb_mdp_result_reader;
    import mdp_pkg::*;

    logic                        clk = 1'b0;
    logic                        Reset;
    logic                        MDP_done;
    logic                        ack;
    logic [MAX_CELLS*UTIL_W-1:0] cur_util;
    logic [MAX_CELLS*POL_W-1:0]  policy;
    logic [7:0]                  in_width;
    logic [7:0]                  in_depth;
    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_W-1:0]            out_index;
    logic [7:0]                  out_row;
    logic [7:0]                  out_col;
    logic [UTIL_W-1:0]           out_util;
    logic [POL_W-1:0]            out_policy;
    logic                        out_last;
    logic                        busy;
    logic                        err;
`ifdef MDP_READER_MAXUTIL_EN
    logic [UTIL_W-1:0]           max_util;
    logic [IDX_W-1:0]            max_index;
`endif

    always #5 clk = ~clk;

    mdp_result_reader dut (
        .clk        (clk),
        .Reset      (Reset),
        .MDP_done   (MDP_done),
        .ack        (ack),
        .cur_util   (cur_util),
        .policy     (policy),
        .in_width   (in_width),
        .in_depth   (in_depth),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_util   (out_util),
        .out_policy (out_policy),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
`ifdef MDP_READER_MAXUTIL_EN
        ,
        .max_util   (max_util),
        .max_index  (max_index)
`endif
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference grid contents and shape
    logic [15:0] m_util [MAX_CELLS];
    logic [1:0]  m_pol  [MAX_CELLS];
    int          m_w;
    int          m_d;

    typedef struct {
        int w;
        int d;
        int mode;      // 0: ready=1, 1: ready pattern 1,0,0, 2: random ready
        int hold;      // extra cycles MDP_done stays high in ACK
        int exp_err;
        int exp_beats;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ord_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    task automatic randomize_grid();
        for (int i = 0; i < MAX_CELLS; i++) begin
            m_util[i] = 16'($urandom());
            m_pol[i]  = 2'($urandom());
        end
    endtask

    // Present the reference grid and raise MDP_done across one capture edge.
    task automatic start_capture();
        for (int i = 0; i < MAX_CELLS; i++) begin
            cur_util[i*16 +: 16] = m_util[i];
            policy[i*2 +: 2]     = m_pol[i];
        end
        in_width  = 8'(m_w);
        in_depth  = 8'(m_d);
        MDP_done  = 1'b1;
        out_ready = 1'b0;
        tick();
    endtask

    // Called right after the capture edge: checks every beat, ack timing and
    // the ack/MDP_done release. Inputs are scrambled to prove they are ignored.
    task automatic stream_and_check(input int mode, input int hold, input int exp_err, input int exp_beats);
        int          beat;
        int          cyc;
        int          last_acc;
        int          ack_cyc;
        int          exp_ack;
        logic [39:0] expb;
        logic [15:0] mu;
        int          mi;
        beat     = 0;
        cyc      = 1;
        last_acc = 0;
        ack_cyc  = -1;
        check("busy_after_capture", busy, 1);
        while (ack_cyc < 0 && cyc < 400) begin
            cur_util = {16{$urandom()}};
            policy   = {2{$urandom()}};
            in_width = 8'($urandom());
            if (ack) begin
                ack_cyc = cyc;
            end else begin
                if (out_valid) begin
                    if (exp_err == 0 && beat < exp_beats) begin
                        expb = {5'(beat), 8'(beat / m_w), 8'(beat % m_w), m_util[beat], m_pol[beat],
                                1'(beat == exp_beats - 1)};
                        check($sformatf("beat%0d", beat),
                              {out_index, out_row, out_col, out_util, out_policy, out_last}, expb);
                    end else begin
                        check("unexpected_beat", out_valid, 0);
                    end
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cyc % 3 == 1);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (out_valid && out_ready) begin
                    beat++;
                    last_acc = cyc;
                end
                tick();
                cyc++;
            end
        end
        out_ready = 1'b0;
        if (ack_cyc < 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack within 400 cycles, beats=%0d", beat);
        end else begin
            if (exp_err != 0)   exp_ack = 1;
            else if (mode == 0) exp_ack = exp_beats + 1;
            else                exp_ack = last_acc + 1;
            check("ack_cycle", ack_cyc, exp_ack);
            check("beat_count", beat, exp_beats);
            check("err_flag", err, exp_err);
            check("valid_in_ack", out_valid, 0);
`ifdef MDP_READER_MAXUTIL_EN
            mu = 16'hFC00;
            mi = 0;
            for (int i = 0; i < (exp_err != 0 ? 0 : exp_beats); i++) begin
                if (ord_key(m_util[i]) > ord_key(mu)) begin
                    mu = m_util[i];
                    mi = i;
                end
            end
            check("max_util", max_util, mu);
            check("max_index", max_index, mi);
`endif
            for (int h = 0; h < hold; h++) begin
                tick();
                check("ack_hold", ack, 1);
            end
            MDP_done = 1'b0;
            tick();
            check("ack_fall", ack, 0);
            check("busy_idle", busy, 0);
            tick();
            check("idle_quiet", {ack, out_valid, busy}, 0);
            check("err_sticky", err, exp_err);
        end
    endtask

    vec_t vecs[12];

    initial begin
        int found;
        vecs[0]  = '{w: 4,   d: 3,   mode: 0, hold: 0, exp_err: 0, exp_beats: 12};
        vecs[1]  = '{w: 0,   d: 3,   mode: 0, hold: 0, exp_err: 1, exp_beats: 0};
        vecs[2]  = '{w: 8,   d: 5,   mode: 0, hold: 0, exp_err: 1, exp_beats: 0};
        vecs[3]  = '{w: 1,   d: 1,   mode: 1, hold: 1, exp_err: 0, exp_beats: 1};
        vecs[4]  = '{w: 8,   d: 4,   mode: 2, hold: 0, exp_err: 0, exp_beats: 32};
        vecs[5]  = '{w: 4,   d: 8,   mode: 1, hold: 2, exp_err: 0, exp_beats: 32};
        vecs[6]  = '{w: 33,  d: 1,   mode: 0, hold: 0, exp_err: 1, exp_beats: 0};
        vecs[7]  = '{w: 3,   d: 0,   mode: 0, hold: 0, exp_err: 1, exp_beats: 0};
        vecs[8]  = '{w: 5,   d: 5,   mode: 2, hold: 3, exp_err: 0, exp_beats: 25};
        vecs[9]  = '{w: 255, d: 255, mode: 0, hold: 0, exp_err: 1, exp_beats: 0};
        vecs[10] = '{w: 1,   d: 32,  mode: 2, hold: 0, exp_err: 0, exp_beats: 32};
        vecs[11] = '{w: 7,   d: 3,   mode: 2, hold: 1, exp_err: 0, exp_beats: 21};

        Reset     = 1'b1;
        MDP_done  = 1'b0;
        out_ready = 1'b0;
        cur_util  = '0;
        policy    = '0;
        in_width  = 8'd0;
        in_depth  = 8'd0;
        repeat (3) tick();
        check("rst_ctrl", {ack, out_valid, out_last, busy, err}, 0);
        check("rst_data", {out_index, out_row, out_col, out_util, out_policy}, 0);
`ifdef MDP_READER_MAXUTIL_EN
        check("rst_max", {max_util, max_index}, {16'hFC00, 5'd0});
`endif
        Reset = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);

        // Fixed 4x3 grid with two marked cells, ready tied high
        m_w = 4;
        m_d = 3;
        for (int i = 0; i < MAX_CELLS; i++) begin
            m_util[i] = 16'h0000;
            m_pol[i]  = 2'($urandom());
        end
        m_util[3] = 16'h3C00;
        m_util[7] = 16'hBC00;
        start_capture();
        stream_and_check(0, 0, 0, 12);

        // Same grid, ready pattern 1,0,0,...
        start_capture();
        stream_and_check(1, 0, 0, 12);

        // Illegal width with MDP_done held 5 cycles in ACK
        m_w = 0;
        start_capture();
        stream_and_check(0, 5, 1, 0);

        // Table of shapes with random contents
        for (int v = 0; v < 12; v++) begin
            randomize_grid();
            m_w = vecs[v].w;
            m_d = vecs[v].d;
            start_capture();
            stream_and_check(vecs[v].mode, vecs[v].hold, vecs[v].exp_err, vecs[v].exp_beats);
        end

        // Reset while beat 5 of 12 is presented, MDP_done still high
        randomize_grid();
        m_w = 4;
        m_d = 3;
        start_capture();
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            if (out_valid && out_index == 5'd5) begin
                found = 1;
            end else begin
                out_ready = 1'b1;
                tick();
            end
        end
        out_ready = 1'b0;
        if (found == 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL reset_wait: got no beat 5 within 30 cycles");
        end
        Reset = 1'b1;
        tick();
        check("midrst_ctrl", {ack, out_valid, out_last, busy, err}, 0);
        check("midrst_data", {out_index, out_row, out_col, out_util, out_policy}, 0);
        Reset = 1'b0;
        tick();
        stream_and_check(0, 0, 0, 12);

`ifdef MDP_READER_MAXUTIL_EN
        // Running maximum with a tie: the lower index must win
        m_w = 2;
        m_d = 2;
        m_util[0] = 16'hBC00;
        m_util[1] = 16'h3800;
        m_util[2] = 16'h3C00;
        m_util[3] = 16'h3C00;
        start_capture();
        stream_and_check(0, 0, 0, 4);
        check("max_util_fixed", max_util, 16'h3C00);
        check("max_index_fixed", max_index, 2);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
